// File: rtl/dpram_stream_tx_pkg.sv
// Shared types and constants for the DPRAM page streamer.
// The S_CRC state exists only when DPRAM_STREAM_TX_CRC_EN is defined.
package dpram_stream_tx_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_SHIFT   = 3'd3,
    S_DONE    = 3'd4
`ifdef DPRAM_STREAM_TX_CRC_EN
    , S_CRC   = 3'd5
`endif
  } state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  localparam logic [1:0] BYTE_MSB = 2'd3;
  localparam logic [1:0] BYTE_LSB = 2'd0;

  // CRC-16/CCITT-FALSE advanced by one whole byte, MSB first, no reflection.
  function automatic logic [15:0] crc16_next(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/dpram_stream_tx_crc16_ccitt_byte.sv
// Byte-wide CRC-16/CCITT-FALSE accumulator; used only when DPRAM_STREAM_TX_CRC_EN is defined.
module crc16_ccitt_byte
  import dpram_stream_tx_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_clr,
  input  logic        i_upd,
  input  logic [7:0]  i_data,
  output logic [15:0] o_crc
);

  logic [15:0] r_crc;
  logic [15:0] w_crc_next;

  always_comb w_crc_next = crc16_next(r_crc, i_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_crc <= CRC_INIT;
    end else if (i_clr) begin
      r_crc <= CRC_INIT;
    end else if (i_upd) begin
      r_crc <= w_crc_next;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/dpram_stream_tx.sv
// Reads one DPRAM page on a run pulse and streams it MSB-byte-first over valid/ready.
// Define DPRAM_STREAM_TX_CRC_EN to append a CRC-16/CCITT-FALSE trailer to every page.
module dpram_stream_tx
  import dpram_stream_tx_pkg::*;
#(
  parameter int unsigned P_DPRAM_ADR_WIDTH = 10,
  parameter int unsigned P_RD_LAT          = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_en,
  input  logic                         i_dpram_run,
  input  logic [15:0]                  i_dpram_len,
  output logic                         o_dpram_busy,
  output logic [P_DPRAM_ADR_WIDTH-1:0] o_dpram_addr,
  output logic                         o_dpram_rden,
  input  logic [31:0]                  i_dpram_q,
  output logic [7:0]                   o_tx_data,
  output logic                         o_tx_valid,
  output logic                         o_tx_last,
  input  logic                         i_tx_ready,
  output logic                         o_len_err,
  output logic [15:0]                  o_frame_cnt
);

  localparam int unsigned AdrW = P_DPRAM_ADR_WIDTH;
  localparam int unsigned LenW = AdrW + 1;
  localparam logic [16:0] DepthExt = 17'(1) << AdrW;
  localparam logic [LenW-1:0] Depth = LenW'(1) << AdrW;
  localparam logic [1:0] WaitLast = 2'(P_RD_LAT - 1);

  state_t            r_state;
  logic [LenW-1:0]   r_len;
  logic [AdrW-1:0]   r_word_cnt;
  logic [1:0]        r_wait;
  logic [31:0]       r_shift;
  logic [1:0]        r_byte_idx;
  logic              r_busy;
  logic              r_rden;
  logic [AdrW-1:0]   r_addr;
  logic              r_valid;
  logic              r_len_err;
  logic [15:0]       r_frame_cnt;

  logic              w_start;
  logic              w_len_over;
  logic [LenW-1:0]   w_len_eff;
  logic              w_last_word;
  logic              w_accept;

  assign w_start     = (r_state == S_IDLE) && i_dpram_run && i_en;
  assign w_len_over  = {1'b0, i_dpram_len} > DepthExt;
  assign w_len_eff   = w_len_over ? Depth : LenW'(i_dpram_len);
  assign w_last_word = ({1'b0, r_word_cnt} + LenW'(1)) == r_len;
  assign w_accept    = r_valid && i_tx_ready;

`ifdef DPRAM_STREAM_TX_CRC_EN
  logic        r_crc_hi;
  logic [15:0] w_crc;

  crc16_ccitt_byte u_crc (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_start),
    .i_upd  ((r_state == S_SHIFT) && w_accept),
    .i_data (r_shift[31:24]),
    .o_crc  (w_crc)
  );

  assign o_tx_data = (r_state == S_CRC) ? (r_crc_hi ? w_crc[15:8] : w_crc[7:0])
                                        : r_shift[31:24];
  assign o_tx_last = r_valid && (r_state == S_CRC) && !r_crc_hi;
`else
  assign o_tx_data = r_shift[31:24];
  assign o_tx_last = r_valid && (r_state == S_SHIFT) && (r_byte_idx == BYTE_LSB) && w_last_word;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_wait      <= '0;
      r_shift     <= '0;
      r_byte_idx  <= '0;
      r_busy      <= 1'b0;
      r_rden      <= 1'b0;
      r_addr      <= '0;
      r_valid     <= 1'b0;
      r_len_err   <= 1'b0;
      r_frame_cnt <= '0;
`ifdef DPRAM_STREAM_TX_CRC_EN
      r_crc_hi    <= 1'b0;
`endif
    end else begin
      r_len_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_len      <= w_len_eff;
            r_word_cnt <= '0;
            r_busy     <= 1'b1;
            r_len_err  <= w_len_over;
            if (w_len_eff == '0) begin
`ifdef DPRAM_STREAM_TX_CRC_EN
              r_valid  <= 1'b1;
              r_crc_hi <= 1'b1;
              r_state  <= S_CRC;
`else
              r_state  <= S_DONE;
`endif
            end else begin
              r_rden  <= 1'b1;
              r_addr  <= '0;
              r_state <= S_RD_REQ;
            end
          end
        end
        S_RD_REQ: begin
          r_rden  <= 1'b0;
          r_wait  <= '0;
          r_state <= S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (r_wait == WaitLast) begin
            r_shift    <= i_dpram_q;
            r_byte_idx <= BYTE_MSB;
            r_valid    <= 1'b1;
            r_state    <= S_SHIFT;
          end else begin
            r_wait <= r_wait + 2'd1;
          end
        end
        S_SHIFT: begin
          if (w_accept) begin
            r_shift    <= {r_shift[23:0], 8'h00};
            r_byte_idx <= r_byte_idx - 2'd1;
            if (r_byte_idx == BYTE_LSB) begin
              if (w_last_word) begin
`ifdef DPRAM_STREAM_TX_CRC_EN
                r_crc_hi <= 1'b1;
                r_state  <= S_CRC;
`else
                r_valid  <= 1'b0;
                r_state  <= S_DONE;
`endif
              end else begin
                // No prefetch: the next word is requested only once this one has drained.
                r_valid    <= 1'b0;
                r_word_cnt <= r_word_cnt + 1'b1;
                r_addr     <= r_word_cnt + 1'b1;
                r_rden     <= 1'b1;
                r_state    <= S_RD_REQ;
              end
            end
          end
        end
`ifdef DPRAM_STREAM_TX_CRC_EN
        S_CRC: begin
          if (w_accept) begin
            if (r_crc_hi) begin
              r_crc_hi <= 1'b0;
            end else begin
              r_valid <= 1'b0;
              r_state <= S_DONE;
            end
          end
        end
`endif
        S_DONE: begin
          r_busy      <= 1'b0;
          r_frame_cnt <= r_frame_cnt + 16'd1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_dpram_busy = r_busy;
  assign o_dpram_addr = r_addr;
  assign o_dpram_rden = r_rden;
  assign o_tx_valid   = r_valid;
  assign o_len_err    = r_len_err;
  assign o_frame_cnt  = r_frame_cnt;

endmodule

// File: tb/tb_dpram_stream_tx.sv
// Self-checking bench for dpram_stream_tx: vector table, DPRAM model and byte-stream reference.
module tb_dpram_stream_tx;

  localparam int AW     = 10;
  localparam int RD_LAT = 1;
  localparam int DEPTH  = 1 << AW;
`ifdef DPRAM_STREAM_TX_CRC_EN
  localparam int CRCB = 2;
`else
  localparam int CRCB = 0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic          dpram_run = 1'b0;
  logic [15:0]   dpram_len = '0;
  logic          busy;
  logic [AW-1:0] addr;
  logic          rden;
  logic [31:0]   q;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          tx_last;
  logic          tx_ready = 1'b0;
  logic          len_err;
  logic [15:0]   frame_cnt;

  dpram_stream_tx #(
    .P_DPRAM_ADR_WIDTH (AW),
    .P_RD_LAT          (RD_LAT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (en),
    .i_dpram_run  (dpram_run),
    .i_dpram_len  (dpram_len),
    .o_dpram_busy (busy),
    .o_dpram_addr (addr),
    .o_dpram_rden (rden),
    .i_dpram_q    (q),
    .o_tx_data    (tx_data),
    .o_tx_valid   (tx_valid),
    .o_tx_last    (tx_last),
    .i_tx_ready   (tx_ready),
    .o_len_err    (len_err),
    .o_frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  // DPRAM model with RD_LAT-cycle read latency; logs every read address.
  logic [31:0]   mem [DEPTH];
  logic [31:0]   pipe [3];
  logic [AW-1:0] rd_log [$];
  always @(posedge clk) begin
    if (rden) begin
      pipe[0] <= mem[addr];
      rd_log.push_back(addr);
    end
    for (int k = 1; k < 3; k++) pipe[k] <= pipe[k-1];
  end
  assign q = pipe[RD_LAT-1];

  // 0: always ready, 1: toggle, 2: random, 3: held low
  int ready_mode = 0;
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       tx_ready = 1'b1;
      1:       tx_ready = ~tx_ready;
      2:       tx_ready = 1'($urandom_range(0, 1));
      default: tx_ready = 1'b0;
    endcase
  end

  // Stream monitor, sampled on the falling edge.
  logic [7:0] cap_byte [$];
  logic       cap_last [$];
  int         busy_cyc = 0;
  int         lenerr_cnt = 0;
  int         stab_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = '0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) begin
        cap_byte.push_back(tx_data);
        cap_last.push_back(tx_last);
      end
      if (busy) busy_cyc++;
      if (len_err) lenerr_cnt++;
      if (prev_stall && (!tx_valid || tx_data != prev_data)) stab_err++;
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  int n_checks = 0;
  int n_fail = 0;
  int frames = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit-serial LFSR form of CRC-16/CCITT-FALSE.
  function automatic logic [15:0] crc_ref(input logic [15:0] crc, input logic [7:0] b);
    logic [15:0] c;
    logic fb;
    c = crc;
    for (int i = 7; i >= 0; i--) begin
      fb = c[15] ^ b[i];
      c  = {c[14:0], 1'b0};
      if (fb) c = c ^ 16'h1021;
    end
    return c;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 20000; k++) begin
      if (!busy) break;
      tick();
    end
    check("busy_fall_in_time", {31'd0, busy}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] len;
    int          mode;
    int          kind;    // 0 random data, 1 two-word page, 2 "1234"
    bit          exp_err;
    bit          timing;  // exact busy length, only valid with ready held high
    bit          inject;  // extra run and en drop mid-page
  } vec_t;

  task automatic run_page(input vec_t v);
    logic [7:0]  exp_q [$];
    logic [15:0] crc;
    int nw, b0, r0, busy0, le0, nb, mism, lc, lpos, am;
    if (v.kind == 1) begin
      mem[0] = 32'h1122_3344;
      mem[1] = 32'hA5A5_5A5A;
    end else if (v.kind == 2) begin
      mem[0] = 32'h3132_3334;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    end
    nw  = (int'(v.len) > DEPTH) ? DEPTH : int'(v.len);
    crc = 16'hFFFF;
    for (int w = 0; w < nw; w++) begin
      for (int b = 3; b >= 0; b--) begin
        exp_q.push_back(mem[w][8*b +: 8]);
        crc = crc_ref(crc, mem[w][8*b +: 8]);
      end
    end
    if (CRCB == 2) begin
      exp_q.push_back(crc[15:8]);
      exp_q.push_back(crc[7:0]);
    end

    ready_mode = v.mode;
    b0 = cap_byte.size(); r0 = rd_log.size(); busy0 = busy_cyc; le0 = lenerr_cnt;
    check("busy_low_before_run", {31'd0, busy}, 32'd0);
    dpram_len = v.len;
    dpram_run = 1'b1;
    tick();
    dpram_run = 1'b0;
    check("busy_one_cycle_after_run", {31'd0, busy}, 32'd1);
    if (v.inject) begin
      tick(); tick();
      dpram_run = 1'b1;
      dpram_len = 16'd7;
      tick();
      dpram_run = 1'b0;
      tick(); tick();
      en = 1'b0;
    end
    wait_idle();
    frames++;

    nb = cap_byte.size() - b0;
    check("byte_count", nb, exp_q.size());
    mism = 0; lc = 0; lpos = -1;
    for (int i = 0; i < nb; i++) begin
      if (i >= exp_q.size() || cap_byte[b0+i] != exp_q[i]) mism++;
      if (cap_last[b0+i]) begin
        lc++;
        lpos = i;
      end
    end
    check("byte_values", mism, 0);
    check("last_count", lc, (exp_q.size() > 0) ? 1 : 0);
    if (exp_q.size() > 0) check("last_on_final_byte", lpos, exp_q.size() - 1);
    check("read_count", rd_log.size() - r0, nw);
    am = 0;
    for (int i = 0; i < nw && r0 + i < rd_log.size(); i++) begin
      if (rd_log[r0+i] != AW'(i)) am++;
    end
    check("read_addresses", am, 0);
    check("len_err_pulses", lenerr_cnt - le0, {31'd0, v.exp_err});
    check("frame_cnt", {16'd0, frame_cnt}, frames);
    check("stall_stability", stab_err, 0);
    if (v.timing) check("busy_cycles", busy_cyc - busy0, nw * (RD_LAT + 5) + CRCB + 1);
    if (v.inject) begin
      tick(); tick(); tick();
      check("extra_run_ignored", {31'd0, busy}, 32'd0);
      en = 1'b1;
    end
  endtask

  vec_t vecs [12];

  initial begin
    int l0, r0;
    vecs[0] = '{len: 16'd2,     mode: 0, kind: 1, exp_err: 0, timing: 1, inject: 0};
    vecs[1] = '{len: 16'd2,     mode: 1, kind: 1, exp_err: 0, timing: 0, inject: 0};
    vecs[2] = '{len: 16'd0,     mode: 0, kind: 0, exp_err: 0, timing: 1, inject: 0};
    vecs[3] = '{len: 16'h0500,  mode: 0, kind: 0, exp_err: 1, timing: 1, inject: 0};
    vecs[4] = '{len: 16'd1,     mode: 0, kind: 2, exp_err: 0, timing: 1, inject: 0};
    vecs[5] = '{len: 16'd3,     mode: 0, kind: 0, exp_err: 0, timing: 1, inject: 1};
    vecs[6] = '{len: 16'd1024,  mode: 2, kind: 0, exp_err: 0, timing: 0, inject: 0};
    vecs[7] = '{len: 16'd1025,  mode: 0, kind: 0, exp_err: 1, timing: 1, inject: 0};
    for (int i = 8; i < 12; i++) begin
      vecs[i] = '{len: 16'($urandom_range(1, 20)), mode: 2, kind: 0, exp_err: 0, timing: 0,
                  inject: 0};
    end

    repeat (3) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rden", {31'd0, rden}, 32'd0);
    check("rst_addr", {22'd0, addr}, 32'd0);
    check("rst_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_last", {31'd0, tx_last}, 32'd0);
    check("rst_data", {24'd0, tx_data}, 32'd0);
    check("rst_len_err", {31'd0, len_err}, 32'd0);
    check("rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    rst_n = 1'b1;
    en    = 1'b1;
    tick();

    for (int i = 0; i < 12; i++) run_page(vecs[i]);

    // Run with en low is dropped.
    en = 1'b0;
    r0 = rd_log.size();
    dpram_len = 16'd4;
    dpram_run = 1'b1;
    tick();
    dpram_run = 1'b0;
    tick(); tick();
    check("run_dropped_busy", {31'd0, busy}, 32'd0);
    check("run_dropped_reads", rd_log.size() - r0, 0);
    en = 1'b1;

    // Reset in the middle of a stalled byte.
    ready_mode = 3;
    dpram_len  = 16'd4;
    dpram_run  = 1'b1;
    tick();
    dpram_run = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (tx_valid) break;
      tick();
    end
    check("reached_shift", {31'd0, tx_valid}, 32'd1);
    l0 = cap_last.size();
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", {31'd0, tx_valid}, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_frame_cnt", {16'd0, frame_cnt}, 32'd0);
    tick();
    rst_n = 1'b1;
    frames = 0;
    ready_mode = 0;
    repeat (5) tick();
    check("no_bytes_after_rst", cap_last.size() - l0, 0);
    check("idle_after_rst", {31'd0, busy}, 32'd0);
    run_page(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
